// File: rtl/nearest_point_stream_scanner.sv
// Streaming nearest-point scanner: one target, then CHANNEL_COUNT candidates.
// Optional macro NEAREST_SCAN_DISTANCE_PIPELINE_EN registers the distance stage.
module nearest_point_stream_scanner #(
  parameter  int PER_DIMENSION_WIDTH = 4,
  parameter  int CHANNEL_COUNT       = 6,
  localparam int ADDRESS_WIDTH  = 3*PER_DIMENSION_WIDTH,
  localparam int CHANNEL_WIDTH  = $clog2(CHANNEL_COUNT),
  localparam int DISTANCE_WIDTH = PER_DIMENSION_WIDTH+2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      target_valid,
  output logic                      target_ready,
  input  logic [ADDRESS_WIDTH-1:0]  target,
  input  logic                      point_valid,
  output logic                      point_ready,
  input  logic [ADDRESS_WIDTH-1:0]  point,
  input  logic                      point_present,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [CHANNEL_WIDTH-1:0]  result_idx,
  output logic [DISTANCE_WIDTH-1:0] result_distance,
  output logic                      result_found
);

  localparam int W  = PER_DIMENSION_WIDTH;
  localparam int CW = CHANNEL_WIDTH;
  localparam int DW = DISTANCE_WIDTH;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e            state_q, state_d;
  logic [3*W-1:0]    tgt_q, tgt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bv_q, bv_d;
  logic [DW-1:0]     bd_q, bd_d;
  logic [CW-1:0]     bi_q, bi_d;
  logic              rf_q, rf_d;
  logic [CW-1:0]     ri_q, ri_d;
  logic [DW-1:0]     rd_q, rd_d;

  logic              tgt_hs, pt_hs, last_c, take;
  logic [DW-1:0]     dist_c;
  logic              upd_en, upd_pres, upd_last;
  logic [DW-1:0]     upd_dist;
  logic [CW-1:0]     upd_idx;

  function automatic logic [DW-1:0] adiff(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    return (a > b) ? DW'(a - b) : DW'(b - a);
  endfunction

  assign tgt_hs = target_valid && target_ready;
  assign pt_hs  = point_valid && point_ready;
  assign last_c = (cnt_q == CW'(CHANNEL_COUNT-1));

  assign dist_c = adiff(point[3*W-1:2*W], tgt_q[3*W-1:2*W])
                + adiff(point[2*W-1:W],   tgt_q[2*W-1:W])
                + adiff(point[W-1:0],     tgt_q[W-1:0]);

`ifdef NEAREST_SCAN_DISTANCE_PIPELINE_EN
  logic          pv_q, pp_q, pl_q, drain_q;
  logic [DW-1:0] pd_q;
  logic [CW-1:0] pi_q;

  // drain_q blocks further beats while the last one sits in the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= 1'b0;
      pp_q    <= 1'b0;
      pl_q    <= 1'b0;
      pd_q    <= '0;
      pi_q    <= '0;
      drain_q <= 1'b0;
    end else begin
      pv_q <= pt_hs;
      pp_q <= point_present;
      pl_q <= last_c;
      pd_q <= dist_c;
      pi_q <= cnt_q;
      if (tgt_hs)
        drain_q <= 1'b0;
      else if (pt_hs && last_c)
        drain_q <= 1'b1;
    end
  end

  assign upd_en   = pv_q;
  assign upd_pres = pp_q;
  assign upd_last = pl_q;
  assign upd_dist = pd_q;
  assign upd_idx  = pi_q;
  assign point_ready = (state_q == COLLECT) && !drain_q;
`else
  assign upd_en   = pt_hs;
  assign upd_pres = point_present;
  assign upd_last = last_c;
  assign upd_dist = dist_c;
  assign upd_idx  = cnt_q;
  assign point_ready = (state_q == COLLECT);
`endif

  // strict compare keeps the lower channel on a tie
  assign take = upd_en && upd_pres && (!bv_q || upd_dist < bd_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tgt_hs) state_d = COLLECT;
      COLLECT: if (upd_en && upd_last) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    target_ready = (state_q == IDLE);
    result_valid = (state_q == DONE);
  end

  always_comb begin
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    bv_d  = bv_q;
    bd_d  = bd_q;
    bi_d  = bi_q;
    rf_d  = rf_q;
    ri_d  = ri_q;
    rd_d  = rd_q;
    if (tgt_hs) begin
      tgt_d = target;
      cnt_d = '0;
      bv_d  = 1'b0;
    end
    if (pt_hs && !last_c) cnt_d = cnt_q + 1'b1;
    if (take) begin
      bv_d = 1'b1;
      bd_d = upd_dist;
      bi_d = upd_idx;
    end
    if (upd_en && upd_last) begin
      rf_d = bv_d;
      ri_d = bv_d ? bi_d : '0;
      rd_d = bv_d ? bd_d : '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= '0;
      cnt_q <= '0;
      bv_q  <= 1'b0;
      bd_q  <= '0;
      bi_q  <= '0;
      rf_q  <= 1'b0;
      ri_q  <= '0;
      rd_q  <= '0;
    end else begin
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      bv_q  <= bv_d;
      bd_q  <= bd_d;
      bi_q  <= bi_d;
      rf_q  <= rf_d;
      ri_q  <= ri_d;
      rd_q  <= rd_d;
    end
  end

  assign result_idx      = ri_q;
  assign result_distance = rd_q;
  assign result_found    = rf_q;

endmodule

// File: tb/tb_nearest_point_stream_scanner.sv
// Randomized and directed bench for nearest_point_stream_scanner.
// Results are checked against a plain-arithmetic nearest-point model.
module tb_nearest_point_stream_scanner;

  localparam int N  = 6;
  localparam int AW = 12;
  localparam int CW = 3;
  localparam int DW = 6;

  typedef logic [AW-1:0] pts_t [N];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          target_valid, target_ready;
  logic [AW-1:0] target;
  logic          point_valid, point_ready, point_present;
  logic [AW-1:0] point;
  logic          result_valid, result_ready, result_found;
  logic [CW-1:0] result_idx;
  logic [DW-1:0] result_distance;

  int n_chk  = 0;
  int n_fail = 0;

  nearest_point_stream_scanner dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .target_valid    (target_valid),
    .target_ready    (target_ready),
    .target          (target),
    .point_valid     (point_valid),
    .point_ready     (point_ready),
    .point           (point),
    .point_present   (point_present),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_idx      (result_idx),
    .result_distance (result_distance),
    .result_found    (result_found)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model(input logic [AW-1:0] t, input pts_t p,
                                input logic [N-1:0] pr, output logic f,
                                output int idx, output int d);
    f = 1'b0; idx = 0; d = 63;
    for (int i = 0; i < N; i++) begin
      if (pr[i]) begin
        int s;
        s = iabs(int'(p[i][11:8]) - int'(t[11:8]))
          + iabs(int'(p[i][7:4]) - int'(t[7:4]))
          + iabs(int'(p[i][3:0]) - int'(t[3:0]));
        if (!f || s < d) begin
          f = 1'b1; idx = i; d = s;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_target(input logic [AW-1:0] t);
    int k = 0;
    target = t;
    target_valid = 1'b1;
    while (!target_ready && k < 20) begin tick(); k++; end
    if (!target_ready) chk("tgt_timeout", 0, 1);
    tick();
    target_valid = 1'b0;
  endtask

  task automatic send_point(input logic [AW-1:0] p, input logic pr,
                            input int gap);
    int k = 0;
    repeat (gap) begin
      point = AW'($urandom);
      point_present = 1'($urandom);
      tick();
    end
    point = p;
    point_present = pr;
    point_valid = 1'b1;
    while (!point_ready && k < 20) begin tick(); k++; end
    if (!point_ready) chk("pt_timeout", 0, 1);
    tick();
    point_valid = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [AW-1:0] t,
                         input pts_t p, input logic [N-1:0] pr,
                         input int gap, input int hold);
    logic ef;
    int ei, ed;
    model(t, p, pr, ef, ei, ed);
    send_target(t);
    for (int i = 0; i < N; i++) begin
      if (i > 0) chk({tag, "_early"}, result_valid, 0);
      send_point(p[i], pr[i], gap);
    end
`ifdef NEAREST_SCAN_DISTANCE_PIPELINE_EN
    chk({tag, "_lat0"}, result_valid, 0);
    tick();
`endif
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_idx"}, result_idx, ei);
    chk({tag, "_dist"}, result_distance, ed);
    chk({tag, "_found"}, result_found, ef);
    repeat (hold) begin
      target_valid = 1'b1;
      point_valid = 1'b1;
      tick();
      chk({tag, "_hold_v"}, result_valid, 1);
      chk({tag, "_hold_tr"}, target_ready, 0);
      chk({tag, "_hold_pr"}, point_ready, 0);
      chk({tag, "_hold_idx"}, result_idx, ei);
      chk({tag, "_hold_dist"}, result_distance, ed);
    end
    target_valid = 1'b0;
    point_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({tag, "_drop"}, result_valid, 0);
    chk({tag, "_idle"}, target_ready, 1);
    chk({tag, "_keep"}, result_distance, ed);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tr"}, target_ready, 1);
    chk({tag, "_pr"}, point_ready, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_idx"}, result_idx, 0);
    chk({tag, "_dist"}, result_distance, 0);
    chk({tag, "_found"}, result_found, 0);
  endtask

  initial begin
    pts_t p;
    logic [N-1:0] pr;
    rst_n = 1'b0;
    target_valid = 1'b0;
    target = '0;
    point_valid = 1'b0;
    point = '0;
    point_present = 1'b0;
    result_ready = 1'b0;
    #12;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    p = '{12'h000, 12'h236, 12'h235, 12'h335, 12'hFFF, 12'h234};
    run_job("elect", 12'h235, p, 6'b111111, 0, 0);
    p = '{12'h111, 12'h003, 12'h030, 12'h444, 12'h444, 12'h444};
    run_job("tie", 12'h000, p, 6'b111111, 0, 1);
    p = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h777, 12'h000};
    run_job("mask", 12'h000, p, 6'b010000, 0, 0);
    run_job("empty", 12'h5A3, p, 6'b000000, 0, 0);
    p = '{12'h9A1, 12'h123, 12'h8F0, 12'h0C4, 12'h9A0, 12'h777};
    run_job("gaps", 12'h9A2, p, 6'b111111, 2, 5);
    run_job("b2b", 12'h123, p, 6'b101101, 0, 0);

    send_target(12'h235);
    for (int i = 0; i < 3; i++) send_point(12'hABC, 1'b1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    p = '{12'h000, 12'h236, 12'h235, 12'h335, 12'hFFF, 12'h234};
    run_job("postrst", 12'h235, p, 6'b111111, 0, 0);

    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++) p[i] = AW'($urandom);
      pr = N'($urandom | $urandom);
      if (j % 5 == 4) pr = '0;
      run_job("rand", AW'($urandom), p, pr,
              $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nearest_point_stream_scanner.md
Name: nearest_point_stream_scanner

Overview:
- Sequential, streaming counterpart to the combinational nearest-point tree solver.
- Accepts one target coordinate, then CHANNEL_COUNT candidate points, one per cycle, from the upstream neighbour-collection stage.
- Computes the 3D Manhattan distance of each candidate to the target and tracks the running minimum.
- Emits the elected channel index and its distance on a valid/ready result port for the downstream matching logic.

Parameters:
- PER_DIMENSION_WIDTH, 4, width of each coordinate (z, x, y).
- CHANNEL_COUNT, 6, number of candidate beats per job (>=2).
- Derived localparams:
  - ADDRESS_WIDTH = 3*PER_DIMENSION_WIDTH
  - CHANNEL_WIDTH = $clog2(CHANNEL_COUNT)
  - DISTANCE_WIDTH = PER_DIMENSION_WIDTH+2

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- target_valid  input  1  target beat valid.
- target_ready  output  1  scanner can accept a target.
- target  input  ADDRESS_WIDTH  packed coordinate: z in MSBs, x in middle, y in LSBs.
- point_valid  input  1  candidate beat valid.
- point_ready  output  1  scanner can accept a candidate.
- point  input  ADDRESS_WIDTH  candidate coordinate, same packing as target.
- point_present  input  1  1 = real candidate; 0 = empty slot, excluded from the election.
- result_valid  output  1  result available.
- result_ready  input  1  downstream accepts the result.
- result_idx  output  CHANNEL_WIDTH  channel number (beat order, 0-based) of the nearest present point.
- result_distance  output  DISTANCE_WIDTH  Manhattan distance of the elected point.
- result_found  output  1  at least one present point was seen.

Behaviour:
- Clocking and reset: single clock domain (clk). Reset is asynchronous, active-low (rst_n). All state flops clear on rst_n low, independent of clk.
- Reset values:
  - state=IDLE
  - target_ready=1 (combinational from IDLE); point_ready=0; result_valid=0
  - result_idx=0; result_distance=0; result_found=0
  - internal beat counter=0; best_valid=0
- Handshake rule: a transfer occurs on a rising clk edge with valid&&ready. Ready signals are functions of state only, never of the corresponding valid.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - target_ready=1.
  - On target handshake: latch target, counter:=0, best_valid:=0, go to COLLECT.
- COLLECT:
  - point_ready=1.
  - Each point handshake: dist = |pz-tz| + |px-tx| + |py-ty|. Each term is zero-extended to DISTANCE_WIDTH before the add; no overflow (max 3*(2^W-1)).
  - Update the best entry if point_present && (!best_valid || dist < best_dist). Comparison is strict: on a tie the lower channel index wins.
  - On the handshake with counter==CHANNEL_COUNT-1: go to DONE and register the outputs. Otherwise counter++.
  - Idle cycles (point_valid=0) hold all state.
- DONE:
  - result_valid=1.
  - Outputs stay stable until result_ready.
  - If best_valid=0: result_found=0, result_idx=0, result_distance=all ones.
  - On result handshake: go to IDLE. result_* retain their last values; result_valid drops.
- Latency: result_valid rises on the cycle after the final point handshake. Minimum job duration is 1 + CHANNEL_COUNT + 1 cycles. Back-to-back: a new target is accepted on the cycle after result acceptance.
- Boundaries:
  - target_valid is ignored outside IDLE.
  - point_valid is ignored outside COLLECT and not consumed.
  - rst_n asserted mid-job discards the partial job; the next job starts clean.
  - CHANNEL_COUNT that is not a power of two needs no special handling; the counter compares against CHANNEL_COUNT-1.

Optional Feature:
- Macro: NEAREST_SCAN_DISTANCE_PIPELINE_EN.
- When defined:
  - The distance computation and the present flag/index are registered in one extra stage before the compare/update.
  - point_ready timing is unchanged.
  - Transition to DONE occurs once the last beat has left the pipeline register, so result_valid rises two cycles after the final point handshake.
  - The pipeline register is cleared by rst_n.
- When undefined: single-stage compare, latency as above.

Test Plan:
- Election: W=4, CHANNEL_COUNT=6, target 0x235; points 0x000, 0x236, 0x235, 0x335, 0xFFF, 0x234, all present -> result_idx=2, result_distance=0, result_found=1.
- Tie-break: target 0x000; points 0x111, 0x003, 0x030, 0x444, 0x444, 0x444, all present -> idx=0, distance=3.
- Mask: target 0x000; only channel 4 present with point 0x777; others 0x000 with present=0 -> idx=4, distance=21, found=1.
- Empty job: all present=0 -> found=0, idx=0, distance=6'h3F. Result_valid one cycle after beat 5 (two with NEAREST_SCAN_DISTANCE_PIPELINE_EN).
- Backpressure/gaps:
  - Insert point_valid gaps of 2 cycles.
  - Hold result_ready=0 for 5 cycles -> outputs stable and target_ready=0 throughout.
  - Ready high -> IDLE next cycle; second job accepted immediately after with correct result.
- Reset mid-job: pulse rst_n low asynchronously after 3 point beats -> all outputs return to reset values without a clk edge. A fresh job then yields the correct result.
